behavioral_model: RTL and testbench
===================================

BEHAVIORAL_MODEL -- requirements
Module: behavioral_model

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; port names are clk and reset.
REQ-002 Parameter LEN, default 8, SHALL set the sequence length in states; legal range 2..8.
REQ-003 Parameter PATTERN, default 8'b1011_0010, SHALL hold the output bit per state, bit 0 emitted first.
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge clock for all state.
REQ-005 Port reset, input, 1 bit, SHALL be the asynchronous active-low reset (0 = reset asserted).
REQ-006 Port y, output, 1 bit, SHALL carry the registered serial pattern bit.

Function
REQ-007 The block SHALL be an autonomous Moore sequence generator with no data inputs.
REQ-008 The block SHALL hold a 3-bit state index idx, encoded as binary, with states S0..S(LEN-1).
REQ-009 On each rising clk edge with reset high, the block SHALL update y <= PATTERN[idx].
REQ-010 On the same edge, idx SHALL advance to idx+1, or wrap to 0 when idx == LEN-1.
REQ-011 y SHALL come directly from a flip-flop, with no combinational path from idx to y.
REQ-012 Latency: the first rising edge after reset deassertion SHALL present PATTERN[0] on y. Edge k (k >= 1) SHALL present PATTERN[(k-1) mod LEN].
REQ-013 The output period SHALL be exactly LEN clock cycles, with no idle or skipped states at wrap-around.
REQ-014 PATTERN bits at index >= LEN SHALL be ignored.
REQ-015 A LEN value outside 2..8 SHALL cause an elaboration-time error.
REQ-016 Any unreachable idx value SHALL return to S0 on the next edge.

Reset
REQ-017 While reset is low, idx SHALL be 0 and y SHALL be 0, regardless of clk.
REQ-018 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-019 Reset mid-sequence SHALL abandon the current position; the sequence restarts at PATTERN[0] on the first edge after release.
REQ-020 Reset deassertion coinciding with a rising edge SHALL NOT advance state on that edge; the next edge is the first active edge.

Configuration
REQ-021 With macro BEHAVIORAL_MODEL_DBG_EN defined, the block SHALL add two outputs:
- state_dbg, 3 bits, mirroring idx;
- wrap, 1 bit, registered, high for exactly one cycle on the edge where idx wraps from LEN-1 to 0.
REQ-022 Under BEHAVIORAL_MODEL_DBG_EN, state_dbg and wrap SHALL reset to 0.
REQ-023 Without BEHAVIORAL_MODEL_DBG_EN, those ports and their logic SHALL be absent, and y behaviour SHALL be unchanged.

Verification
REQ-024 Defaults; reset low for 10 ns, then released; 16 edges -> y = 0,1,0,0,1,1,0,1,0,1,0,0,1,1,0,1.
REQ-025 Reset held low across 5 edges -> y stays 0; reset low asynchronously between edges -> y drops to 0 before the next edge.
REQ-026 Reset pulsed low after edge 3 -> the following edges restart at y = 0,1,0,0,...
REQ-027 LEN=3, PATTERN=8'b0000_0110; 6 edges -> y = 0,1,1,0,1,1.
REQ-028 With BEHAVIORAL_MODEL_DBG_EN and defaults -> wrap high only on edges 8, 16, 24; state_dbg counts 1..7,0 repeating.
REQ-029 LEN=9 -> elaboration fails.

Source files
------------

// File: rtl/behavioral_model.sv
// behavioral_model: autonomous Moore serial pattern generator.
// A binary state index walks S0..S(LEN-1) and wraps with no idle states.
// Each clock edge registers PATTERN[idx] onto y, so bit 0 appears on the
// first edge after reset is released.
// Optional debug outputs are enabled by defining BEHAVIORAL_MODEL_DBG_EN:
//   state_dbg - mirrors the state index.
//   wrap      - registered, high for one cycle after the LEN-1 -> 0 step.
module behavioral_model #(
  parameter int         LEN     = 8,
  parameter logic [7:0] PATTERN = 8'b1011_0010
) (
  input  logic       clk,
  input  logic       reset,
  output logic       y
`ifdef BEHAVIORAL_MODEL_DBG_EN
  ,
  output logic [2:0] state_dbg,
  output logic       wrap
`endif
);

  // Refuse to build with a sequence length the 3-bit index cannot hold
  // or that would make the pattern degenerate.
  generate
    if ((LEN < 2) || (LEN > 8)) begin : g_len_check
      $error("behavioral_model: LEN must be within 2..8");
    end
  endgenerate

  // Index of the last state; the index wraps after reaching it.
  localparam logic [2:0] LAST_IDX = 3'(LEN - 1);

  // Pattern bits at positions >= LEN are cleared. Any out-of-range index
  // would therefore read 0; such an index also returns to S0 on the next edge.
  localparam logic [7:0] PAT_MASK = 8'hFF >> (8 - LEN);
  localparam logic [7:0] PAT_EFF  = PATTERN & PAT_MASK;

  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic       y_q;
  logic       y_d;
`ifdef BEHAVIORAL_MODEL_DBG_EN
  logic       wrap_q;
  logic       wrap_d;
`endif

  // Next-state logic: advance or wrap the index and select the next output bit.
  always_comb begin
    idx_d  = idx_q + 3'd1;
    y_d    = PAT_EFF[idx_q];
`ifdef BEHAVIORAL_MODEL_DBG_EN
    wrap_d = 1'b0;
`endif
    if (idx_q >= LAST_IDX) begin
      // The last state wraps to S0. An unreachable index also recovers to S0.
      idx_d  = 3'd0;
`ifdef BEHAVIORAL_MODEL_DBG_EN
      wrap_d = (idx_q == LAST_IDX);
`endif
    end else begin
      idx_d  = idx_q + 3'd1;
`ifdef BEHAVIORAL_MODEL_DBG_EN
      wrap_d = 1'b0;
`endif
    end
  end

  // State and output registers. Reset clears them at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= 3'd0;
      y_q    <= 1'b0;
`ifdef BEHAVIORAL_MODEL_DBG_EN
      wrap_q <= 1'b0;
`endif
    end else begin
      idx_q  <= idx_d;
      y_q    <= y_d;
`ifdef BEHAVIORAL_MODEL_DBG_EN
      wrap_q <= wrap_d;
`endif
    end
  end

  assign y = y_q;

`ifdef BEHAVIORAL_MODEL_DBG_EN
  assign state_dbg = idx_q;
  assign wrap      = wrap_q;
`endif

endmodule

// File: tb/tb_behavioral_model.sv
// Self-checking bench for behavioral_model.
// Table-driven vectors for the documented sequences, hand-written reset
// corner cases, then randomized reset activity checked against a reference
// model that counts active edges since reset release.
module tb_behavioral_model;

  logic clk;
  logic reset;
  logic y_def;
  logic y_l3;
  logic y_l5;

  localparam logic [7:0] PAT_DEF = 8'b1011_0010;
  localparam logic [7:0] PAT_L3  = 8'b0000_0110;
  localparam logic [7:0] PAT_L5  = 8'b1110_0101;

  int n_checks = 0;
  int n_errors = 0;

  // Active edges since reset release, one counter per instance.
  int k_def;
  int k_l3;
  int k_l5;

`ifdef BEHAVIORAL_MODEL_DBG_EN
  logic [2:0] sd_def, sd_l3, sd_l5;
  logic       wr_def, wr_l3, wr_l5;
`endif

  behavioral_model u_def (
    .clk(clk), .reset(reset), .y(y_def)
`ifdef BEHAVIORAL_MODEL_DBG_EN
    , .state_dbg(sd_def), .wrap(wr_def)
`endif
  );

  behavioral_model #(.LEN(3), .PATTERN(PAT_L3)) u_l3 (
    .clk(clk), .reset(reset), .y(y_l3)
`ifdef BEHAVIORAL_MODEL_DBG_EN
    , .state_dbg(sd_l3), .wrap(wr_l3)
`endif
  );

  behavioral_model #(.LEN(5), .PATTERN(PAT_L5)) u_l5 (
    .clk(clk), .reset(reset), .y(y_l5)
`ifdef BEHAVIORAL_MODEL_DBG_EN
    , .state_dbg(sd_l5), .wrap(wr_l5)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: count active edges since the last reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_def <= 0;
      k_l3  <= 0;
      k_l5  <= 0;
    end else begin
      k_def <= k_def + 1;
      k_l3  <= k_l3 + 1;
      k_l5  <= k_l5 + 1;
    end
  end

  // Edge k >= 1 shows pattern bit (k-1) mod len; the output is 0 during reset.
  function automatic logic exp_y(input logic [7:0] pat, input int len, input int k);
    logic [7:0] p;
    p = pat;
    if (k == 0) return 1'b0;
    return p[(k - 1) % len];
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("rand_y_def", {7'd0, y_def}, {7'd0, exp_y(PAT_DEF, 8, k_def)});
    chk("rand_y_l3",  {7'd0, y_l3},  {7'd0, exp_y(PAT_L3, 3, k_l3)});
    chk("rand_y_l5",  {7'd0, y_l5},  {7'd0, exp_y(PAT_L5, 5, k_l5)});
`ifdef BEHAVIORAL_MODEL_DBG_EN
    chk("dbg_state_def", {5'd0, sd_def}, 8'(k_def % 8));
    chk("dbg_wrap_def",  {7'd0, wr_def}, {7'd0, (k_def > 0) && (k_def % 8 == 0)});
    chk("dbg_state_l3",  {5'd0, sd_l3},  8'(k_l3 % 3));
    chk("dbg_wrap_l3",   {7'd0, wr_l3},  {7'd0, (k_l3 > 0) && (k_l3 % 3 == 0)});
`endif
  endtask

  typedef struct {
    logic rst_v;
    logic y_def_exp;
    logic y_l3_exp;
  } vec_t;

  vec_t tbl[21];

  // Reset pulse after edge 3 must restart at 0,1,0,0.
  logic [3:0] restart_exp;

  initial begin
    // Five edges held in reset, then sixteen free-running edges.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 1'b0};
    restart_exp = 4'b0010; // bit i is edge i+1: 0,1,0,0

    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset_y_def", {7'd0, y_def}, 8'd0);
    chk("reset_y_l3",  {7'd0, y_l3},  8'd0);

    // Table-driven sequence.
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      reset = tbl[i].rst_v;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_y_def", i), {7'd0, y_def}, {7'd0, tbl[i].y_def_exp});
      chk($sformatf("tbl%0d_y_l3", i),  {7'd0, y_l3},  {7'd0, tbl[i].y_l3_exp});
    end

    // Asynchronous reset between edges: y (currently 1) drops at once.
    chk("pre_async_y_def", {7'd0, y_def}, 8'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_y_def", {7'd0, y_def}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Three edges, then a reset pulse between edges.
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("pre_pulse_e%0d", e + 1), {7'd0, y_def}, {7'd0, PAT_DEF[e]});
    end
    #2 reset = 1'b0;
    #1;
    chk("pulse_y_low", {7'd0, y_def}, 8'd0);
    #1 reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("restart_e%0d", e + 1), {7'd0, y_def}, {7'd0, restart_exp[e]});
    end

    // Randomized reset activity against the reference model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 11) != 0);
      @(posedge clk);
      #1;
      chk_model();
      if ($urandom_range(0, 19) == 0) begin
        #1 reset = 1'b0;
        #1;
        chk_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
